// File: rtl/e_mdu_ctrl.sv
// E-stage multiply/divide unit: owns HI/LO, computes the result up front,
// and holds Busy for a fixed latency before committing the result.
module e_mdu_ctrl #(
  parameter int MUL_CYCLES = 5,
  parameter int DIV_CYCLES = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] A,
  input  logic [31:0] B,
  input  logic [3:0]  E_MDUOp,
  input  logic        Start,
  input  logic        Req,
  output logic        Busy,
  output logic [31:0] HI,
  output logic [31:0] LO,
  output logic [31:0] E_MDUOut
);

  typedef enum logic {IDLE, RUN} state_t;

  localparam logic [3:0] OP_MULT  = 4'd1;
  localparam logic [3:0] OP_MULTU = 4'd2;
  localparam logic [3:0] OP_DIV   = 4'd3;
  localparam logic [3:0] OP_DIVU  = 4'd4;
  localparam logic [3:0] OP_MTHI  = 4'd5;
  localparam logic [3:0] OP_MTLO  = 4'd6;
  localparam logic [3:0] OP_MFHI  = 4'd7;
  localparam logic [3:0] OP_MFLO  = 4'd8;

  state_t r_state;
  state_t w_nextState;

  logic [31:0] r_hi;
  logic [31:0] r_lo;
  logic [31:0] r_tempHi;
  logic [31:0] r_tempLo;
  logic [7:0]  r_count;
  logic        r_skip;

  logic        w_isMdu;
  logic        w_isDiv;
  logic        w_start;
  logic        w_ovf;
  logic [31:0] w_divB;
  logic [31:0] w_sDivB;
  logic signed [63:0] w_sProd;
  logic [63:0] w_uProd;
  logic [31:0] w_uQuot;
  logic [31:0] w_uRem;
  logic signed [31:0] w_sQuot;
  logic signed [31:0] w_sRem;
  logic [31:0] w_resHi;
  logic [31:0] w_resLo;

  assign w_isMdu = (E_MDUOp == OP_MULT) || (E_MDUOp == OP_MULTU) ||
                   (E_MDUOp == OP_DIV)  || (E_MDUOp == OP_DIVU);
  assign w_isDiv = (E_MDUOp == OP_DIV) || (E_MDUOp == OP_DIVU);
  assign w_start = Start && !Req && w_isMdu;

  // Divisors are steered away from zero and the signed overflow pair so the
  // dividers never see an undefined case; r_skip discards the zero-divide result.
  assign w_ovf   = (A == 32'h8000_0000) && (B == 32'hFFFF_FFFF);
  assign w_divB  = (B == 32'd0) ? 32'd1 : B;
  assign w_sDivB = w_ovf ? 32'd1 : w_divB;

  assign w_sProd = $signed({{32{A[31]}}, A}) * $signed({{32{B[31]}}, B});
  assign w_uProd = {32'd0, A} * {32'd0, B};
  assign w_uQuot = A / w_divB;
  assign w_uRem  = A % w_divB;
  assign w_sQuot = $signed(A) / $signed(w_sDivB);
  assign w_sRem  = $signed(A) % $signed(w_sDivB);

  always_comb begin
    w_resHi = 32'd0;
    w_resLo = 32'd0;
    case (E_MDUOp)
      OP_MULT:  {w_resHi, w_resLo} = w_sProd;
      OP_MULTU: {w_resHi, w_resLo} = w_uProd;
      OP_DIV:   begin w_resHi = w_sRem; w_resLo = w_sQuot; end
      OP_DIVU:  begin w_resHi = w_uRem; w_resLo = w_uQuot; end
      default:  ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_nextState;
  end

  always_comb begin
    w_nextState = r_state;
    case (r_state)
      IDLE:    if (w_start) w_nextState = RUN;
      RUN:     if (r_count == 8'd1) w_nextState = IDLE;
      default: w_nextState = IDLE;
    endcase
  end

  always_comb begin
    Busy     = (r_state == RUN);
    E_MDUOut = 32'd0;
    if (E_MDUOp == OP_MFHI)      E_MDUOut = r_hi;
    else if (E_MDUOp == OP_MFLO) E_MDUOut = r_lo;
  end

  // MTHI/MTLO only act in IDLE; while running, the completion is the sole HI/LO writer.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_hi     <= 32'd0;
      r_lo     <= 32'd0;
      r_tempHi <= 32'd0;
      r_tempLo <= 32'd0;
      r_count  <= 8'd0;
      r_skip   <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_start) begin
            r_tempHi <= w_resHi;
            r_tempLo <= w_resLo;
            r_count  <= w_isDiv ? 8'(DIV_CYCLES) : 8'(MUL_CYCLES);
            r_skip   <= w_isDiv && (B == 32'd0);
          end else if (!Req && (E_MDUOp == OP_MTHI)) begin
            r_hi <= A;
          end else if (!Req && (E_MDUOp == OP_MTLO)) begin
            r_lo <= A;
          end
        end
        RUN: begin
          r_count <= r_count - 8'd1;
          if ((r_count == 8'd1) && !r_skip) begin
            r_hi <= r_tempHi;
            r_lo <= r_tempLo;
          end
        end
        default: ;
      endcase
    end
  end

  assign HI = r_hi;
  assign LO = r_lo;

endmodule

// File: tb/tb_e_mdu_ctrl.sv
// Scoreboard bench for e_mdu_ctrl: completions and snapshots are queued by
// the stimulus process and checked by an independent negedge monitor.
module tb_e_mdu_ctrl;

  logic        clk;
  logic        reset;
  logic [31:0] A;
  logic [31:0] B;
  logic [3:0]  E_MDUOp;
  logic        Start;
  logic        Req;
  logic        Busy;
  logic [31:0] HI;
  logic [31:0] LO;
  logic [31:0] E_MDUOut;

  typedef struct {
    string       tag;
    logic [31:0] hi;
    logic [31:0] lo;
    logic [31:0] out;
    int          cycles;
  } exp_t;

  exp_t doneQ[$];
  exp_t snapQ[$];
  logic snapReq;
  int   checks;
  int   errors;

  e_mdu_ctrl #(.MUL_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk(clk), .reset(reset), .A(A), .B(B), .E_MDUOp(E_MDUOp),
    .Start(Start), .Req(Req), .Busy(Busy), .HI(HI), .LO(LO),
    .E_MDUOut(E_MDUOut)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic compare(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  // Monitor: pops a completion entry on each Busy falling edge, a snapshot entry on request.
  initial begin
    logic prevBusy;
    int   busyRun;
    exp_t e;
    prevBusy = 1'b0;
    busyRun  = 0;
    forever begin
      @(negedge clk);
      if (prevBusy && (Busy !== 1'b1)) begin
        if (doneQ.size() == 0) begin
          checks++;
          errors++;
          $display("[TB] FAIL unexpected_done: got completion after %0d busy cycles expected none", busyRun);
        end else begin
          e = doneQ.pop_front();
          compare({e.tag, "_HI"}, HI, e.hi);
          compare({e.tag, "_LO"}, LO, e.lo);
          compare({e.tag, "_cycles"}, 32'(busyRun), 32'(e.cycles));
        end
        busyRun = 0;
      end
      if (Busy === 1'b1) busyRun++;
      prevBusy = (Busy === 1'b1);
      if (snapReq) begin
        if (snapQ.size() == 0) begin
          checks++;
          errors++;
          $display("[TB] FAIL snap_queue: got empty queue expected entry");
        end else begin
          e = snapQ.pop_front();
          compare({e.tag, "_HI"}, HI, e.hi);
          compare({e.tag, "_LO"}, LO, e.lo);
          compare({e.tag, "_OUT"}, E_MDUOut, e.out);
          compare({e.tag, "_Busy"}, 32'(Busy), 32'd0);
        end
      end
    end
  end

  task automatic applyStimulus(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                               input logic st, input logic rq);
    E_MDUOp = op; A = a; B = b; Start = st; Req = rq;
    @(posedge clk); #1;
    E_MDUOp = 4'd0; A = 32'd0; B = 32'd0; Start = 1'b0; Req = 1'b0;
  endtask

  task automatic checkOutput(input string tag, input logic [3:0] op, input logic [31:0] hi,
                             input logic [31:0] lo, input logic [31:0] out);
    snapQ.push_back('{tag, hi, lo, out, 0});
    E_MDUOp = op;
    snapReq = 1'b1;
    @(posedge clk); #1;
    snapReq = 1'b0;
    E_MDUOp = 4'd0;
  endtask

  task automatic expectDone(input string tag, input logic [31:0] hi, input logic [31:0] lo,
                            input int cycles);
    doneQ.push_back('{tag, hi, lo, 32'd0, cycles});
  endtask

  task automatic waitIdle(input string tag);
    int n;
    n = 0;
    while ((Busy === 1'b1) && (n < 40)) begin
      @(posedge clk); #1;
      n++;
    end
    if (Busy === 1'b1) begin
      checks++;
      errors++;
      $display("[TB] FAIL %s_timeout: got Busy=1 after %0d cycles expected 0", tag, n);
    end
    @(posedge clk); #1;
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got no finish expected finish before 200000");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    checks = 0; errors = 0; snapReq = 1'b0;
    A = 32'd0; B = 32'd0; E_MDUOp = 4'd0; Start = 1'b0; Req = 1'b0;
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;

    checkOutput("reset_mfhi", 4'd7, 32'd0, 32'd0, 32'd0);
    checkOutput("reset_mflo", 4'd8, 32'd0, 32'd0, 32'd0);

    expectDone("mult", 32'hFFFF_FFFF, 32'hFFFF_FFFA, 5);
    applyStimulus(4'd1, 32'hFFFF_FFFE, 32'd3, 1'b1, 1'b0);
    waitIdle("mult");

    expectDone("multu", 32'hFFFF_FFFE, 32'h0000_0001, 5);
    applyStimulus(4'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 1'b0);
    waitIdle("multu");

    expectDone("div", 32'hFFFF_FFFF, 32'hFFFF_FFFD, 10);
    applyStimulus(4'd3, 32'hFFFF_FFF9, 32'd2, 1'b1, 1'b0);
    waitIdle("div");
    checkOutput("div_mfhi", 4'd7, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 32'hFFFF_FFFF);
    checkOutput("div_mflo", 4'd8, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 32'hFFFF_FFFD);

    applyStimulus(4'd5, 32'h11, 32'd0, 1'b0, 1'b0);
    applyStimulus(4'd6, 32'h22, 32'd0, 1'b0, 1'b0);
    checkOutput("mthi_mtlo", 4'd0, 32'h11, 32'h22, 32'd0);
    expectDone("divu_zero", 32'h11, 32'h22, 10);
    applyStimulus(4'd4, 32'd100, 32'd0, 1'b1, 1'b0);
    waitIdle("divu_zero");

    expectDone("div_ovf", 32'h0, 32'h8000_0000, 10);
    applyStimulus(4'd3, 32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 1'b0);
    waitIdle("div_ovf");

    applyStimulus(4'd1, 32'd2, 32'd3, 1'b1, 1'b1);
    repeat (7) begin @(posedge clk); #1; end
    checkOutput("start_req", 4'd0, 32'h0, 32'h8000_0000, 32'd0);

    applyStimulus(4'd5, 32'd5, 32'd0, 1'b0, 1'b1);
    checkOutput("mthi_req", 4'd7, 32'h0, 32'h8000_0000, 32'h0);

    // -100 / 7: quotient -14, remainder -2; Req and a stray Start arrive mid-run.
    expectDone("div_req", 32'hFFFF_FFFE, 32'hFFFF_FFF2, 10);
    applyStimulus(4'd3, 32'hFFFF_FF9C, 32'd7, 1'b1, 1'b0);
    repeat (2) begin @(posedge clk); #1; end
    applyStimulus(4'd0, 32'd0, 32'd0, 1'b0, 1'b1);
    applyStimulus(4'd1, 32'd9, 32'd9, 1'b1, 1'b0);
    waitIdle("div_req");

    expectDone("mult_reset", 32'h0, 32'h0, 3);
    applyStimulus(4'd1, 32'd4, 32'd4, 1'b1, 1'b0);
    repeat (2) begin @(posedge clk); #1; end
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    checkOutput("after_reset", 4'd8, 32'h0, 32'h0, 32'h0);

    expectDone("mult_4x4", 32'h0, 32'd16, 5);
    applyStimulus(4'd1, 32'd4, 32'd4, 1'b1, 1'b0);
    waitIdle("mult_4x4");
    checkOutput("mflo_16", 4'd8, 32'h0, 32'd16, 32'd16);

    repeat (3) begin @(posedge clk); #1; end
    compare("doneQ_empty", 32'(doneQ.size()), 32'd0);
    compare("snapQ_empty", 32'(snapQ.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
